// File: rtl/rs_age_issue_pkg.sv
// Shared definitions for the age-ordered ALU reservation station.
// Holds the default widths used as parameter defaults, the NOP opcode value
// and the "no dependency" ROB tag value.
package rs_age_issue_pkg;

  localparam int DEF_RS_DEPTH = 16;
  localparam int DEF_ROB_W    = 4;
  localparam int DEF_DATA_W   = 32;
  localparam int DEF_OP_W     = 6;
  localparam int DEF_NUM_CDB  = 3;

  // Opcode 0 is a bubble and is never accepted into the station.
  localparam int OP_NOP   = 0;

  // A source tag of 0 means the operand value is already valid.
  localparam int ZERO_ROB = 0;

endpackage

// File: rtl/rs_age_issue_age_matrix.sv
// Age matrix for an N-entry reservation station.
// Tracks the relative age of all live entries and grants the oldest ready one.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   rdy       global enable; low holds the matrix
//   flush     clears all age relations
//   alloc     one-hot entry being written this cycle (becomes youngest)
//   free      one-hot entry being issued this cycle
//   ready     per-entry ready vector (from registered entry state)
//   grant     one-hot oldest-ready entry, all zero when nothing is ready
module rs_age_matrix #(
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rdy,
  input  logic         flush,
  input  logic [N-1:0] alloc,
  input  logic [N-1:0] free,
  input  logic [N-1:0] ready,
  output logic [N-1:0] grant
);

  // older_q[i][j] set means entry i was dispatched before entry j.
  logic [N-1:0][N-1:0] older_q, older_d;

  // A new entry is younger than everything already resident, so its column is
  // set and its own row cleared. Freed entries drop out of every relation.
  always_comb begin
    older_d = older_q;
    if (flush) begin
      older_d = '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        for (int j = 0; j < N; j++) begin
          if (alloc[j] && (i != j)) older_d[i][j] = 1'b1;
          if (alloc[i])             older_d[i][j] = 1'b0;
          if (free[i] || free[j])   older_d[i][j] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      older_q <= '0;
    end else if (rdy) begin
      older_q <= older_d;
    end
  end

  // An entry wins when it is ready and no other ready entry is older than it.
  // Live entries form a total order, so at most one bit is set.
  always_comb begin
    grant = '0;
    for (int i = 0; i < N; i++) begin
      grant[i] = ready[i];
      for (int j = 0; j < N; j++) begin
        if (ready[j] && older_q[j][i]) grant[i] = 1'b0;
      end
    end
  end

endmodule

// File: rtl/rs_age_issue.sv
// ALU reservation station that issues the oldest ready entry.
// Ports:
//   clk, rst, rdy      clock, async active-high reset, global enable
//   in_flush           misprediction flush, highest priority
//   in_disp_*          dispatch request: op, destination ROB tag, operands,
//                      source tags (0 = value valid), immediate and pc
//   in_cdb_*           NUM_CDB packed broadcast channels (valid/tag/value)
//   out_full/out_count occupancy, from the registered count
//   out_alu_*          registered issue to the ALU, out_alu_valid is a strobe
module rs_age_issue
  import rs_age_issue_pkg::*;
#(
  parameter int RS_DEPTH = DEF_RS_DEPTH,
  parameter int ROB_W    = DEF_ROB_W,
  parameter int DATA_W   = DEF_DATA_W,
  parameter int OP_W     = DEF_OP_W,
  parameter int NUM_CDB  = DEF_NUM_CDB
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      rdy,
  input  logic                      in_flush,
  input  logic                      in_disp_valid,
  input  logic [OP_W-1:0]           in_disp_op,
  input  logic [ROB_W-1:0]          in_disp_rob,
  input  logic [DATA_W-1:0]         in_disp_val1,
  input  logic [DATA_W-1:0]         in_disp_val2,
  input  logic [DATA_W-1:0]         in_disp_imm,
  input  logic [DATA_W-1:0]         in_disp_pc,
  input  logic [ROB_W-1:0]          in_disp_tag1,
  input  logic [ROB_W-1:0]          in_disp_tag2,
  input  logic [NUM_CDB-1:0]        in_cdb_valid,
  input  logic [NUM_CDB*ROB_W-1:0]  in_cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0] in_cdb_value,
  output logic                      out_full,
  output logic [$clog2(RS_DEPTH):0] out_count,
  output logic                      out_alu_valid,
  output logic [OP_W-1:0]           out_alu_op,
  output logic [DATA_W-1:0]         out_alu_val1,
  output logic [DATA_W-1:0]         out_alu_val2,
  output logic [DATA_W-1:0]         out_alu_imm,
  output logic [DATA_W-1:0]         out_alu_pc,
  output logic [ROB_W-1:0]          out_alu_rob
);

  localparam int CNT_W = $clog2(RS_DEPTH) + 1;

  // Entry storage. Only the valid bits need a reset; payload is don't-care
  // while an entry is invalid.
  logic [RS_DEPTH-1:0] valid_q, valid_d;
  logic [OP_W-1:0]     op_q   [RS_DEPTH];
  logic [ROB_W-1:0]    rob_q  [RS_DEPTH];
  logic [ROB_W-1:0]    tag1_q [RS_DEPTH];
  logic [ROB_W-1:0]    tag2_q [RS_DEPTH];
  logic [DATA_W-1:0]   val1_q [RS_DEPTH];
  logic [DATA_W-1:0]   val2_q [RS_DEPTH];
  logic [DATA_W-1:0]   imm_q  [RS_DEPTH];
  logic [DATA_W-1:0]   pc_q   [RS_DEPTH];

  logic [CNT_W-1:0]  count_q, count_d;
  logic              aluValid_q, aluValid_d;
  logic [OP_W-1:0]   aluOp_q, aluOp_d;
  logic [ROB_W-1:0]  aluRob_q, aluRob_d;
  logic [DATA_W-1:0] aluVal1_q, aluVal1_d, aluVal2_q, aluVal2_d;
  logic [DATA_W-1:0] aluImm_q, aluImm_d, aluPc_q, aluPc_d;

  logic [RS_DEPTH-1:0] readyVec, grantVec, freeSlot, allocVec;
  logic                fullNow, dispAccept, issueAny;
  logic [DATA_W:0]     fwd1, fwd2;
  logic [DATA_W:0]     look1 [RS_DEPTH];
  logic [DATA_W:0]     look2 [RS_DEPTH];
  logic [OP_W-1:0]     selOp;
  logic [ROB_W-1:0]    selRob;
  logic [DATA_W-1:0]   selVal1, selVal2, selImm, selPc;

  // Returns {hit, value}. Scanning from the top channel down lets the lowest
  // matching channel overwrite the others.
  function automatic logic [DATA_W:0] cdbLookup(
    input logic [ROB_W-1:0]          tag,
    input logic [NUM_CDB-1:0]        cValid,
    input logic [NUM_CDB*ROB_W-1:0]  cTag,
    input logic [NUM_CDB*DATA_W-1:0] cVal
  );
    logic [DATA_W:0] res;
    res = '0;
    if (tag != ROB_W'(ZERO_ROB)) begin
      for (int k = NUM_CDB - 1; k >= 0; k--) begin
        if (cValid[k] && (cTag[k*ROB_W +: ROB_W] == tag)) begin
          res = {1'b1, cVal[k*DATA_W +: DATA_W]};
        end
      end
    end
    return res;
  endfunction

  assign fullNow    = (count_q == CNT_W'(RS_DEPTH));
  assign dispAccept = in_disp_valid && (in_disp_op != OP_W'(OP_NOP)) &&
                      (in_disp_rob != ROB_W'(ZERO_ROB)) && !fullNow;
  assign allocVec   = dispAccept ? freeSlot : '0;
  assign issueAny   = |grantVec;
  assign valid_d    = in_flush ? '0 : ((valid_q & ~grantVec) | allocVec);

  // Lowest-index free slot. An entry issuing this cycle still counts as
  // occupied, so its slot only becomes reusable the following cycle.
  always_comb begin
    freeSlot = '0;
    for (int i = RS_DEPTH - 1; i >= 0; i--) begin
      if (!valid_q[i]) begin
        freeSlot    = '0;
        freeSlot[i] = 1'b1;
      end
    end
  end

  // Ready uses registered tags only, so a wakeup becomes issuable one edge later.
  always_comb begin
    fwd1 = cdbLookup(in_disp_tag1, in_cdb_valid, in_cdb_tag, in_cdb_value);
    fwd2 = cdbLookup(in_disp_tag2, in_cdb_valid, in_cdb_tag, in_cdb_value);
    for (int i = 0; i < RS_DEPTH; i++) begin
      look1[i]    = cdbLookup(tag1_q[i], in_cdb_valid, in_cdb_tag, in_cdb_value);
      look2[i]    = cdbLookup(tag2_q[i], in_cdb_valid, in_cdb_tag, in_cdb_value);
      readyVec[i] = valid_q[i] && (tag1_q[i] == ROB_W'(ZERO_ROB)) &&
                    (tag2_q[i] == ROB_W'(ZERO_ROB));
    end
  end

  rs_age_matrix #(.N(RS_DEPTH)) u_age (
    .clk   (clk),
    .rst   (rst),
    .rdy   (rdy),
    .flush (in_flush),
    .alloc (allocVec),
    .free  (grantVec),
    .ready (readyVec),
    .grant (grantVec)
  );

  // The grant is one-hot, so OR-ing the granted entry's fields acts as a mux.
  always_comb begin
    selOp = '0; selRob = '0; selVal1 = '0; selVal2 = '0; selImm = '0; selPc = '0;
    for (int i = 0; i < RS_DEPTH; i++) begin
      if (grantVec[i]) begin
        selOp   |= op_q[i];
        selRob  |= rob_q[i];
        selVal1 |= val1_q[i];
        selVal2 |= val2_q[i];
        selImm  |= imm_q[i];
        selPc   |= pc_q[i];
      end
    end
  end

  // Issue and count. Without an issue the opcode drops to NOP while the data
  // fields keep their last values.
  always_comb begin
    count_d    = count_q;
    aluValid_d = aluValid_q;
    aluOp_d    = aluOp_q;
    aluRob_d   = aluRob_q;
    aluVal1_d  = aluVal1_q;
    aluVal2_d  = aluVal2_q;
    aluImm_d   = aluImm_q;
    aluPc_d    = aluPc_q;
    if (in_flush) begin
      count_d    = '0;
      aluValid_d = 1'b0;
      aluOp_d    = OP_W'(OP_NOP);
    end else begin
      count_d = count_q + CNT_W'(dispAccept) - CNT_W'(issueAny);
      if (issueAny) begin
        aluValid_d = 1'b1;
        aluOp_d    = selOp;
        aluRob_d   = selRob;
        aluVal1_d  = selVal1;
        aluVal2_d  = selVal2;
        aluImm_d   = selImm;
        aluPc_d    = selPc;
      end else begin
        aluValid_d = 1'b0;
        aluOp_d    = OP_W'(OP_NOP);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q    <= '0;
      count_q    <= '0;
      aluValid_q <= 1'b0;
      aluOp_q    <= '0;
      aluRob_q   <= '0;
      aluVal1_q  <= '0;
      aluVal2_q  <= '0;
      aluImm_q   <= '0;
      aluPc_q    <= '0;
    end else if (rdy) begin
      valid_q    <= valid_d;
      count_q    <= count_d;
      aluValid_q <= aluValid_d;
      aluOp_q    <= aluOp_d;
      aluRob_q   <= aluRob_d;
      aluVal1_q  <= aluVal1_d;
      aluVal2_q  <= aluVal2_d;
      aluImm_q   <= aluImm_d;
      aluPc_q    <= aluPc_d;
    end
  end

  // Payload: a new entry captures forwarded CDB values directly; resident
  // entries capture any matching broadcast and clear the tag.
  always_ff @(posedge clk) begin
    if (rdy && !in_flush) begin
      for (int i = 0; i < RS_DEPTH; i++) begin
        if (allocVec[i]) begin
          op_q[i]   <= in_disp_op;
          rob_q[i]  <= in_disp_rob;
          imm_q[i]  <= in_disp_imm;
          pc_q[i]   <= in_disp_pc;
          tag1_q[i] <= fwd1[DATA_W] ? ROB_W'(ZERO_ROB) : in_disp_tag1;
          val1_q[i] <= fwd1[DATA_W] ? fwd1[DATA_W-1:0] : in_disp_val1;
          tag2_q[i] <= fwd2[DATA_W] ? ROB_W'(ZERO_ROB) : in_disp_tag2;
          val2_q[i] <= fwd2[DATA_W] ? fwd2[DATA_W-1:0] : in_disp_val2;
        end else if (valid_q[i]) begin
          if (look1[i][DATA_W]) begin
            tag1_q[i] <= ROB_W'(ZERO_ROB);
            val1_q[i] <= look1[i][DATA_W-1:0];
          end
          if (look2[i][DATA_W]) begin
            tag2_q[i] <= ROB_W'(ZERO_ROB);
            val2_q[i] <= look2[i][DATA_W-1:0];
          end
        end
      end
    end
  end

  assign out_full      = fullNow;
  assign out_count     = count_q;
  assign out_alu_valid = aluValid_q;
  assign out_alu_op    = aluOp_q;
  assign out_alu_rob   = aluRob_q;
  assign out_alu_val1  = aluVal1_q;
  assign out_alu_val2  = aluVal2_q;
  assign out_alu_imm   = aluImm_q;
  assign out_alu_pc    = aluPc_q;

endmodule

// File: tb/tb_rs_age_issue.sv
// Self-checking bench for rs_age_issue: directed scenarios followed by random
// traffic, all compared against a dispatch-ordered queue model.
module tb_rs_age_issue;

  localparam int DEPTH  = 16;
  localparam int ROB_W  = 4;
  localparam int DATA_W = 32;
  localparam int OP_W   = 6;
  localparam int NCDB   = 3;

  logic                    clk = 1'b0;
  logic                    rst;
  logic                    rdy;
  logic                    flush;
  logic                    dispValid;
  logic [OP_W-1:0]         dispOp;
  logic [ROB_W-1:0]        dispRob, dispTag1, dispTag2;
  logic [DATA_W-1:0]       dispVal1, dispVal2, dispImm, dispPc;
  logic [NCDB-1:0]         cdbValid;
  logic [NCDB*ROB_W-1:0]   cdbTag;
  logic [NCDB*DATA_W-1:0]  cdbValue;
  logic                    outFull;
  logic [$clog2(DEPTH):0]  outCount;
  logic                    aluValid;
  logic [OP_W-1:0]         aluOp;
  logic [DATA_W-1:0]       aluVal1, aluVal2, aluImm, aluPc;
  logic [ROB_W-1:0]        aluRob;

  always #5 clk = ~clk;

  rs_age_issue dut (
    .clk           (clk),
    .rst           (rst),
    .rdy           (rdy),
    .in_flush      (flush),
    .in_disp_valid (dispValid),
    .in_disp_op    (dispOp),
    .in_disp_rob   (dispRob),
    .in_disp_val1  (dispVal1),
    .in_disp_val2  (dispVal2),
    .in_disp_imm   (dispImm),
    .in_disp_pc    (dispPc),
    .in_disp_tag1  (dispTag1),
    .in_disp_tag2  (dispTag2),
    .in_cdb_valid  (cdbValid),
    .in_cdb_tag    (cdbTag),
    .in_cdb_value  (cdbValue),
    .out_full      (outFull),
    .out_count     (outCount),
    .out_alu_valid (aluValid),
    .out_alu_op    (aluOp),
    .out_alu_val1  (aluVal1),
    .out_alu_val2  (aluVal2),
    .out_alu_imm   (aluImm),
    .out_alu_pc    (aluPc),
    .out_alu_rob   (aluRob)
  );

  typedef struct {
    logic [OP_W-1:0]   op;
    logic [ROB_W-1:0]  rob;
    logic [ROB_W-1:0]  t1;
    logic [ROB_W-1:0]  t2;
    logic [DATA_W-1:0] v1;
    logic [DATA_W-1:0] v2;
    logic [DATA_W-1:0] imm;
    logic [DATA_W-1:0] pc;
  } entry_t;

  // Model: queue in dispatch order, so the oldest entry is always at the front.
  entry_t            model[$];
  logic              expValid;
  logic [OP_W-1:0]   expOp;
  logic [ROB_W-1:0]  expRob;
  logic [DATA_W-1:0] expV1, expV2, expImm, expPc;
  bit                skipOp;
  int                checks = 0;
  int                errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    checks++;
    if (obs !== expv) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Lowest matching CDB channel supplies the value for a nonzero tag.
  function automatic logic [DATA_W:0] cdbFind(input logic [ROB_W-1:0] tag);
    if (tag == '0) return '0;
    for (int k = 0; k < NCDB; k++) begin
      if (cdbValid[k] && cdbTag[k*ROB_W +: ROB_W] == tag) return {1'b1, cdbValue[k*DATA_W +: DATA_W]};
    end
    return '0;
  endfunction

  task automatic modelReset();
    model.delete();
    expValid = 1'b0; expOp = '0; expRob = '0;
    expV1 = '0; expV2 = '0; expImm = '0; expPc = '0;
    skipOp = 1'b0;
  endtask

  task automatic modelStep();
    bit wasFull;
    int idx;
    entry_t e;
    logic [DATA_W:0] r;
    if (!rdy) return;
    if (flush) begin
      model.delete();
      expValid = 1'b0;
      skipOp   = 1'b1;
      return;
    end
    skipOp  = 1'b0;
    wasFull = (model.size() == DEPTH);
    idx = -1;
    for (int i = 0; i < model.size(); i++) begin
      if (model[i].t1 == '0 && model[i].t2 == '0) begin
        idx = i;
        break;
      end
    end
    if (idx >= 0) begin
      e = model[idx];
      expValid = 1'b1; expOp = e.op; expRob = e.rob;
      expV1 = e.v1; expV2 = e.v2; expImm = e.imm; expPc = e.pc;
      model.delete(idx);
    end else begin
      expValid = 1'b0;
      expOp    = '0;
    end
    for (int i = 0; i < model.size(); i++) begin
      e = model[i];
      r = cdbFind(e.t1);
      if (r[DATA_W]) begin e.t1 = '0; e.v1 = r[DATA_W-1:0]; end
      r = cdbFind(e.t2);
      if (r[DATA_W]) begin e.t2 = '0; e.v2 = r[DATA_W-1:0]; end
      model[i] = e;
    end
    if (dispValid && dispOp != '0 && dispRob != '0) begin
      if (wasFull) begin
        $display("[TB] protocol error: dispatch while full, request dropped");
      end else begin
        e.op = dispOp; e.rob = dispRob; e.imm = dispImm; e.pc = dispPc;
        e.t1 = dispTag1; e.v1 = dispVal1; e.t2 = dispTag2; e.v2 = dispVal2;
        r = cdbFind(dispTag1);
        if (r[DATA_W]) begin e.t1 = '0; e.v1 = r[DATA_W-1:0]; end
        r = cdbFind(dispTag2);
        if (r[DATA_W]) begin e.t2 = '0; e.v2 = r[DATA_W-1:0]; end
        model.push_back(e);
      end
    end
  endtask

  // Advance the model with the current inputs, clock once, compare after the edge.
  task automatic applyStimulus();
    modelStep();
    @(posedge clk);
    #1;
    checkOutput("count", 64'(outCount), 64'(model.size()));
    checkOutput("full", 64'(outFull), 64'(model.size() == DEPTH));
    checkOutput("aluValid", 64'(aluValid), 64'(expValid));
    if (!skipOp) checkOutput("aluOp", 64'(aluOp), 64'(expOp));
    checkOutput("aluRob", 64'(aluRob), 64'(expRob));
    checkOutput("aluVal1", 64'(aluVal1), 64'(expV1));
    checkOutput("aluVal2", 64'(aluVal2), 64'(expV2));
    checkOutput("aluImm", 64'(aluImm), 64'(expImm));
    checkOutput("aluPc", 64'(aluPc), 64'(expPc));
  endtask

  task automatic idleInputs();
    rdy = 1'b1; flush = 1'b0;
    dispValid = 1'b0; dispOp = '0; dispRob = '0; dispTag1 = '0; dispTag2 = '0;
    dispVal1 = '0; dispVal2 = '0; dispImm = '0; dispPc = '0;
    cdbValid = '0; cdbTag = '0; cdbValue = '0;
  endtask

  task automatic setDispatch(input int op, input int rob, input int t1, input int t2,
                             input logic [DATA_W-1:0] v1, input logic [DATA_W-1:0] v2);
    dispValid = 1'b1;
    dispOp    = OP_W'(op);
    dispRob   = ROB_W'(rob);
    dispTag1  = ROB_W'(t1);
    dispTag2  = ROB_W'(t2);
    dispVal1  = v1;
    dispVal2  = v2;
    dispImm   = $urandom;
    dispPc    = $urandom;
  endtask

  task automatic setCdb(input int ch, input int tag, input logic [DATA_W-1:0] val);
    cdbValid[ch]                 = 1'b1;
    cdbTag[ch*ROB_W +: ROB_W]    = ROB_W'(tag);
    cdbValue[ch*DATA_W +: DATA_W] = val;
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".count"}, 64'(outCount), 64'd0);
    checkOutput({tag, ".full"}, 64'(outFull), 64'd0);
    checkOutput({tag, ".valid"}, 64'(aluValid), 64'd0);
    checkOutput({tag, ".op"}, 64'(aluOp), 64'd0);
    checkOutput({tag, ".val1"}, 64'(aluVal1), 64'd0);
    checkOutput({tag, ".pc"}, 64'(aluPc), 64'd0);
  endtask

  initial begin
    idleInputs();
    rst = 1'b1;
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Ready dispatch issues one cycle after it lands.
    setDispatch(1, 1, 0, 0, 32'h1111, 32'h2222);
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("A.val1", 64'(aluVal1), 64'h1111);
    applyStimulus();

    // Younger ready B overtakes blocked A; A wakes from channel 0.
    setDispatch(2, 2, 5, 0, 32'hA0, 32'hA1);
    applyStimulus();
    idleInputs();
    setDispatch(3, 3, 0, 0, 32'hB0, 32'hB1);
    applyStimulus();
    idleInputs();
    setCdb(0, 5, 32'h1234);
    applyStimulus();
    checkOutput("B.rob", 64'(aluRob), 64'd3);
    idleInputs();
    applyStimulus();
    checkOutput("A.val1", 64'(aluVal1), 64'h1234);
    applyStimulus();

    // Same-cycle forward from channel 2.
    setDispatch(4, 4, 0, 7, 32'hC0, 32'hC1);
    setCdb(2, 7, 32'hDEAD);
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("C.val2", 64'(aluVal2), 64'hDEAD);
    applyStimulus();

    // Fill, overflow attempt, then drain in dispatch order.
    for (int i = 0; i < DEPTH; i++) begin
      idleInputs();
      setDispatch(5, (i % 15) + 1, 3, 0, 32'(i), 32'(i + 100));
      applyStimulus();
    end
    setDispatch(6, 9, 0, 0, 32'hFF, 32'hFF);
    applyStimulus();
    checkOutput("fill.full", 64'(outFull), 64'd1);
    idleInputs();
    setCdb(1, 3, 32'hCAFE);
    applyStimulus();
    idleInputs();
    for (int i = 0; i < DEPTH; i++) applyStimulus();
    applyStimulus();

    // Flush with a simultaneous dispatch discards everything.
    for (int i = 0; i < 5; i++) begin
      idleInputs();
      setDispatch(7, i + 1, 6, 0, 32'(i), 32'(i));
      applyStimulus();
    end
    setDispatch(8, 10, 0, 0, 32'h55, 32'h66);
    flush = 1'b1;
    applyStimulus();
    idleInputs();
    setCdb(0, 6, 32'h77);
    applyStimulus();
    idleInputs();
    repeat (3) applyStimulus();

    // rdy low freezes state even with a matching broadcast present.
    setDispatch(9, 8, 9, 0, 32'h0, 32'h1);
    applyStimulus();
    idleInputs();
    rdy = 1'b0;
    setCdb(0, 9, 32'hBEEF);
    repeat (3) applyStimulus();
    rdy = 1'b1;
    applyStimulus();
    idleInputs();
    applyStimulus();
    checkOutput("D.val1", 64'(aluVal1), 64'hBEEF);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      idleInputs();
      rdy   = ($urandom_range(0, 9) != 0);
      flush = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 2) != 0 && model.size() < DEPTH) begin
        setDispatch($urandom_range(0, 7), $urandom_range(0, 15),
                    ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 7),
                    ($urandom_range(0, 1) != 0) ? 0 : $urandom_range(1, 7),
                    $urandom, $urandom);
      end
      for (int ch = 0; ch < NCDB; ch++) begin
        if ($urandom_range(0, 1) != 0) setCdb(ch, $urandom_range(1, 7), $urandom);
      end
      applyStimulus();
    end

    // Asynchronous reset between clock edges.
    idleInputs();
    setDispatch(10, 11, 0, 0, 32'h3, 32'h4);
    applyStimulus();
    idleInputs();
    applyStimulus();
    #2;
    rst = 1'b1;
    #1;
    checkAllZero("asyncReset");
    modelReset();
    @(negedge clk);
    rst = 1'b0;
    idleInputs();
    repeat (2) applyStimulus();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
